encoder148_latched: RTL and testbench
=====================================

Name: encoder148_latched

Overview:
- Registered 8-to-3 priority encoder with a request/acknowledge handshake. It is the encode-side counterpart of the team's 3-to-8 active-low decoder.
- Eight active-low request lines are synchronised and edge-detected, then latched as pending.
- The highest-numbered pending request is presented as a 3-bit code with VALID and is held until the consumer acknowledges it.
- Provides 74LS148-style cascade signals (EI, GS, EO) so two blocks can form a 16-line encoder.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on I_n and EI; legal range 2..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- EI  input  1  active-low enable in; when high, no new code is presented.
- I_n  input  8  active-low request lines; bit k is request k, and 7 has the highest priority.
- ACK  input  1  one-cycle acknowledge pulse for the presented code.
- CLR_OVR  input  1  one-cycle pulse that clears OVR.
- CODE  output  3  binary index of the presented request (active-high).
- VALID  output  1  CODE is valid and held.
- GS  output  1  active-low group select; equals ~VALID.
- EO  output  1  active-low enable out; low when EI (synchronised) is low and nothing is pending or presented.
- OVR  output  1  sticky overrun flag.

Behaviour:
- Reset (async assert, sync-deassert handled upstream):
  - Synchroniser flops and previous-value register are set to 8'hFF.
  - pending = 0, state = IDLE.
  - CODE = 3'b000, VALID = 0, GS = 1, EO = 1, OVR = 0.
- Synchronisation and edge detection:
  - I_n and EI each pass through SYNC_STAGES flops.
  - A request event on bit k is a 1->0 transition of synchronised I_n[k] against its previous-cycle value.
  - A level held low produces exactly one event.
- Pending register:
  - An event on k sets pending[k].
  - An ACK in HOLD clears pending[CODE].
  - If an event on bit k and a clear of bit k occur in the same cycle, set wins: pending[k] stays 1 and OVR is unchanged.
- Overrun:
  - An event on k while pending[k] is already 1 (and not being cleared that cycle) sets OVR.
  - OVR stays set until CLR_OVR; if CLR_OVR and a new overrun coincide, set wins.
- State machine:
  - IDLE: if synchronised EI == 0 and pending != 0:
    - CODE <= index of the highest set bit of pending;
    - VALID <= 1;
    - go to HOLD.
    - Otherwise remain in IDLE with VALID = 0.
  - HOLD: CODE and VALID stay stable regardless of new events or EI.
    - On ACK: VALID <= 0, clear pending[CODE], go to GAP.
  - GAP: one cycle with VALID = 0, then go to IDLE. This guarantees at least one idle cycle between codes, so the consumer sees distinct VALID pulses.
  - ACK in IDLE or GAP is ignored.
- Latency (SYNC_STAGES = 2, idle block): I_n[k] first sampled low at edge 1 -> pending[k] set at edge 3 -> VALID = 1 after edge 4. In general, VALID rises SYNC_STAGES + 2 edges after the first low sample.
- Back-to-back: after ACK at edge n, VALID = 0 at edges n+1 and n+2; the next code is valid after edge n+2 at the earliest.
- Outputs:
  - GS is registered together with VALID.
  - EO is registered: EO <= ~(EI_sync == 0 && pending == 0 && state == IDLE).
- Reset mid-HOLD drops VALID immediately and discards all pending requests.

Decomposition:
- Shared package:
  - localparam N_REQ = 8;
  - code width 3;
  - state encoding IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2.
- One sub-module, prio_enc8: a purely combinational 8-bit highest-set-bit encoder producing idx[2:0] and any.
- Synchronisers are instantiated per bit inside the top level.

Test Plan:
- Reset: with rst_n = 0 and I_n = 8'hFF -> CODE = 0, VALID = 0, GS = 1, EO = 1, OVR = 0. After release with EI = 0 and no requests -> EO = 0 within SYNC_STAGES + 1 cycles.
- Single request: drive I_n = 8'hF7 (bit 3 low) -> VALID rises 4 edges later with CODE = 3 and GS = 0. ACK pulse -> VALID = 0 for 2 cycles, then stays 0.
- Priority: drive I_n = 8'h5E in one cycle (bits 0, 5, 7 low) -> codes are presented in order 7, 5, 0, one per ACK, each separated by the GAP cycle.
- Enable gating: hold EI = 1 while I_n[6] pulses low -> VALID stays 0 and pending[6] is latched. Drop EI to 0 -> CODE = 6 valid SYNC_STAGES + 1 cycles later.
- Overrun: pulse I_n[2] low twice before any ACK -> OVR = 1 and CODE = 2 presented once. CLR_OVR -> OVR = 0.
- Simultaneous: a new I_n[4] event is detected in the same cycle ACK acknowledges CODE = 4 -> code 4 is re-presented after GAP and OVR stays 0. Reset asserted mid-HOLD -> VALID = 0 immediately, and no code is presented after release.

Source files
------------

// File: rtl/encoder148_latched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : encoder148_latched_pkg
// Purpose  : Shared constants, types and helpers for the latched 8-to-3
//            priority encoder (request count, code width, FSM encoding).
// Revision : 1.0 - initial release
// ============================================================================
package encoder148_latched_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef logic [N_REQ-1:0]  req_t;
    typedef logic [CODE_W-1:0] code_t;

    // FSM encoding kept as plain constants so legacy code can compare directly
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // One-hot mask selecting the request bit addressed by a code
    function automatic req_t onehot(input code_t c);
        return req_t'(1) << c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/encoder148_latched_if.sv
`default_nettype none
// ============================================================================
// Module   : encoder148_latched_if
// Purpose  : Request/acknowledge bundle between a requester/consumer (master)
//            and the latched priority encoder (slave).
// Signals  : EI, I_n, ACK, CLR_OVR  master -> encoder
//            CODE, VALID, GS, EO, OVR encoder -> master
// Revision : 1.0 - initial release
// ============================================================================
interface encoder148_latched_if;
    import encoder148_latched_pkg::*;

    logic  EI;
    req_t  I_n;
    logic  ACK;
    logic  CLR_OVR;
    code_t CODE;
    logic  VALID;
    logic  GS;
    logic  EO;
    logic  OVR;

    modport master (
        output EI, I_n, ACK, CLR_OVR,
        input  CODE, VALID, GS, EO, OVR
    );

    modport slave (
        input  EI, I_n, ACK, CLR_OVR,
        output CODE, VALID, GS, EO, OVR
    );

endinterface
`default_nettype wire

// File: rtl/encoder148_latched_prio_enc8.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc8
// Purpose  : Combinational highest-set-bit encoder for 8 active-high inputs.
// Ports    : i_req [7:0] request vector
//            o_idx [2:0] index of the highest set bit (0 when none set)
//            o_any       at least one bit set
// Revision : 1.0 - initial release
// ============================================================================
module prio_enc8
    import encoder148_latched_pkg::*;
(
    input  wire req_t  i_req,
    output code_t      o_idx,
    output logic       o_any
);

    // Ascending scan: the last hit is the highest-numbered request
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_req[i]) begin
                o_idx = code_t'(i);
            end
        end
        o_any = |i_req;
    end

endmodule
`default_nettype wire

// File: rtl/encoder148_latched.sv
`default_nettype none
// ============================================================================
// Module   : encoder148_latched
// Purpose  : Registered 8-to-3 priority encoder with request/ack handshake and
//            74LS148-style cascade outputs. Active-low requests are
//            synchronised, falling-edge detected and latched as pending; the
//            highest pending index is held on CODE/VALID until acknowledged.
// Ports    : clk    system clock, rising edge
//            rst_n  asynchronous active-low reset
//            bus    encoder148_latched_if.slave (EI, I_n, ACK, CLR_OVR in;
//                   CODE, VALID, GS, EO, OVR out)
// Params   : SYNC_STAGES synchroniser depth on I_n and EI, legal 2..4
// Revision : 1.0 - initial release
// ============================================================================
module encoder148_latched
    import encoder148_latched_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  wire                   clk,
    input  wire                   rst_n,
    encoder148_latched_if.slave   bus
);

    req_t       w_i_sync;
    logic       w_ei_sync;
    req_t       r_prev_i;
    req_t       r_pending;
    req_t       w_ev;
    req_t       w_clr;
    logic       w_ovr_set;
    code_t      w_idx;
    logic       w_any;
    logic [1:0] r_state;
    code_t      r_code;
    logic       r_valid;
    logic       r_gs;
    logic       r_eo;
    logic       r_ovr;
    logic [SYNC_STAGES-1:0] r_ei_chain;

    // Per-bit synchronisers; reset high so no false request after reset
    for (genvar k = 0; k < N_REQ; k++) begin : g_sync_i
        logic [SYNC_STAGES-1:0] r_chain;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_chain <= '1;
            end else begin
                r_chain <= {r_chain[SYNC_STAGES-2:0], bus.I_n[k]};
            end
        end
        assign w_i_sync[k] = r_chain[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ei_chain <= '1;
        end else begin
            r_ei_chain <= {r_ei_chain[SYNC_STAGES-2:0], bus.EI};
        end
    end
    assign w_ei_sync = r_ei_chain[SYNC_STAGES-1];

    // Falling edge of a synchronised line is one request event
    assign w_ev  = r_prev_i & ~w_i_sync;
    assign w_clr = (r_state == ST_HOLD && bus.ACK) ? onehot(r_code) : '0;
    // Overrun only when the bit is already pending and not being retired now
    assign w_ovr_set = |(w_ev & r_pending & ~w_clr);

    prio_enc8 u_prio (
        .i_req (r_pending),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_i  <= '1;
            r_pending <= '0;
            r_ovr     <= 1'b0;
            r_eo      <= 1'b1;
        end else begin
            r_prev_i  <= w_i_sync;
            // Set after clear: a coincident event keeps the bit pending
            r_pending <= (r_pending & ~w_clr) | w_ev;
            r_ovr     <= w_ovr_set | (r_ovr & ~bus.CLR_OVR);
            r_eo      <= ~(!w_ei_sync && !w_any && r_state == ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_gs    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_ei_sync && w_any) begin
                        r_code  <= w_idx;
                        r_valid <= 1'b1;
                        r_gs    <= 1'b0;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.ACK) begin
                        r_valid <= 1'b0;
                        r_gs    <= 1'b1;
                        r_state <= ST_GAP;
                    end
                end
                // Forced idle cycle so consecutive codes are distinct pulses
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_gs    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.CODE  = r_code;
    assign bus.VALID = r_valid;
    assign bus.GS    = r_gs;
    assign bus.EO    = r_eo;
    assign bus.OVR   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_encoder148_latched.sv
`default_nettype none
// ============================================================================
// Module   : tb_encoder148_latched
// Purpose  : Directed self-checking bench for encoder148_latched
//            (SYNC_STAGES = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_encoder148_latched;
    import encoder148_latched_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    encoder148_latched_if bus ();

    encoder148_latched #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        bus.ACK = 1'b1;
        tick();
        bus.ACK = 1'b0;
    endtask

    task automatic pulse_req(input req_t v);
        bus.I_n = v;
        tick();
        bus.I_n = '1;
    endtask

    task automatic wait_valid(input int max_cycles, input string tag);
        int k;
        k = 0;
        while (!bus.VALID && k < max_cycles) begin
            tick();
            k++;
        end
        check({tag, "_wait"}, int'(bus.VALID), 1);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.EI      = 1'b0;
        bus.I_n     = '1;
        bus.ACK     = 1'b0;
        bus.CLR_OVR = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_code",  int'(bus.CODE),  0);
        check("rst_valid", int'(bus.VALID), 0);
        check("rst_gs",    int'(bus.GS),    1);
        check("rst_eo",    int'(bus.EO),    1);
        check("rst_ovr",   int'(bus.OVR),   0);

        rst_n = 1'b1;
        repeat (2) tick();
        check("eo_early", int'(bus.EO), 1);
        tick();
        check("eo_idle", int'(bus.EO), 0);

        // Single request on bit 3, held low
        bus.I_n = 8'hF7;
        repeat (3) tick();
        check("single_lat_pre", int'(bus.VALID), 0);
        tick();
        check("single_valid", int'(bus.VALID), 1);
        check("single_code",  int'(bus.CODE),  3);
        check("single_gs",    int'(bus.GS),    0);
        check("single_eo",    int'(bus.EO),    1);
        ack_pulse();
        check("single_ack0", int'(bus.VALID), 0);
        tick();
        check("single_ack1", int'(bus.VALID), 0);
        tick();
        check("single_ack2", int'(bus.VALID), 0);
        repeat (3) tick();
        check("single_once", int'(bus.VALID), 0);
        bus.I_n = '1;
        repeat (3) tick();

        // Priority order 7, 5, 0 from one simultaneous pulse
        pulse_req(8'h5E);
        wait_valid(8, "prio7");
        check("prio_code7", int'(bus.CODE), 7);
        ack_pulse();
        check("prio_gap_a", int'(bus.VALID), 0);
        tick();
        check("prio_gap_b", int'(bus.VALID), 0);
        tick();
        check("prio_valid5", int'(bus.VALID), 1);
        check("prio_code5",  int'(bus.CODE),  5);
        ack_pulse();
        repeat (2) tick();
        check("prio_valid0", int'(bus.VALID), 1);
        check("prio_code0",  int'(bus.CODE),  0);
        ack_pulse();
        repeat (4) tick();
        check("prio_done", int'(bus.VALID), 0);
        check("prio_ovr",  int'(bus.OVR),   0);

        // Enable gating
        bus.EI = 1'b1;
        repeat (3) tick();
        check("en_eo_high", int'(bus.EO), 1);
        pulse_req(8'hBF);
        repeat (8) tick();
        check("en_blocked", int'(bus.VALID), 0);
        check("en_gs",      int'(bus.GS),    1);
        bus.EI = 1'b0;
        repeat (2) tick();
        check("en_lat_pre", int'(bus.VALID), 0);
        tick();
        check("en_valid", int'(bus.VALID), 1);
        check("en_code",  int'(bus.CODE),  6);
        ack_pulse();
        repeat (3) tick();

        // Overrun: two pulses on bit 2 before acknowledge
        pulse_req(8'hFB);
        tick();
        pulse_req(8'hFB);
        repeat (6) tick();
        check("ovr_set",   int'(bus.OVR),   1);
        check("ovr_valid", int'(bus.VALID), 1);
        check("ovr_code",  int'(bus.CODE),  2);
        ack_pulse();
        repeat (6) tick();
        check("ovr_once",  int'(bus.VALID), 0);
        check("ovr_stick", int'(bus.OVR),   1);
        bus.CLR_OVR = 1'b1;
        tick();
        bus.CLR_OVR = 1'b0;
        check("ovr_clr", int'(bus.OVR), 0);

        // Event on bit 4 coincident with ACK of code 4
        pulse_req(8'hEF);
        wait_valid(8, "sim4");
        check("sim_code4", int'(bus.CODE), 4);
        bus.I_n = 8'hEF;
        tick();
        bus.I_n = '1;
        tick();
        bus.ACK = 1'b1;
        tick();
        bus.ACK = 1'b0;
        check("sim_gap_a", int'(bus.VALID), 0);
        tick();
        check("sim_gap_b", int'(bus.VALID), 0);
        tick();
        check("sim_revalid", int'(bus.VALID), 1);
        check("sim_recode",  int'(bus.CODE),  4);
        check("sim_ovr",     int'(bus.OVR),   0);

        // Reset while holding a code
        #1 rst_n = 1'b0;
        #1;
        check("rst_hold_valid", int'(bus.VALID), 0);
        check("rst_hold_gs",    int'(bus.GS),    1);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("rst_discard", int'(bus.VALID), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
